sat_addsub_serial: RTL and testbench
====================================

SAT_ADDSUB_SERIAL -- requirements
Module: sat_addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width in bits; legal values are multiples of 4, minimum 4.
REQ-002 SHALL derive the local constant SLICES = WIDTH/4, the number of 4-bit slices processed.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; it is synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin an operation; sampled only while ready=1.
REQ-006 SHALL have port sub, input, 1: 0 computes a+b, 1 computes a-b; captured with start.
REQ-007 SHALL have port a, input, WIDTH, the signed two's-complement operand A.
REQ-008 SHALL have port b, input, WIDTH, the signed two's-complement operand B.
REQ-009 SHALL have port ready, output, 1, high only in state IDLE.
REQ-010 SHALL have port busy, output, 1, high only in state BUSY.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse marking result and ovfl valid.
REQ-012 SHALL have port result, output, WIDTH, the final signed result.
REQ-013 SHALL have port ovfl, output, 1, the signed overflow flag of the last completed operation.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-015 SHALL, on an edge in IDLE with start=1, capture a, b and sub, clear the slice counter, load carry=sub, and enter BUSY.
REQ-016 SHALL, on each BUSY edge, process slice i as a[4i+3:4i] + (b[4i+3:4i] XOR {4{sub}}) + carry, store the 4-bit sum in an internal working register, update carry and increment i.
REQ-017 SHALL leave BUSY for DONE on the edge that processes slice SLICES-1.
REQ-018 SHALL make done=1 in DONE for exactly one cycle and return to IDLE on the next edge.
REQ-019 SHALL therefore assert done SLICES edges after the edge that accepted start (4 for WIDTH=16); ready returns the cycle after done.
REQ-020 SHALL detect signed overflow when a[WIDTH-1] equals the effective b MSB (b[WIDTH-1] XOR sub) and the raw result MSB differs from it.
REQ-021 SHALL update result and ovfl only on the edge entering DONE; they hold through IDLE and BUSY until the next completion.
REQ-022 SHALL ignore start while in BUSY or DONE; the captured operands and sub are not disturbed.
REQ-023 SHALL give rst priority over start when both are asserted on the same edge.

Reset
REQ-024 SHALL, on any edge with rst=1 and from any state, enter IDLE, clear the counter and carry, and drive result=0, ovfl=0, done=0, busy=0, ready=1 from the next cycle.
REQ-025 SHALL abort an in-flight operation on rst without producing a done pulse.

Configuration
REQ-026 SHALL, with SAT_ADDSUB_SAT_EN defined, saturate result on overflow: positive overflow gives 2^(WIDTH-1)-1 and negative overflow gives -2^(WIDTH-1); ovfl=1 in both cases.
REQ-027 SHALL, without SAT_ADDSUB_SAT_EN, output the wrapped WIDTH-bit sum; ovfl is still computed per REQ-020.

Verification
REQ-028 WIDTH=16, SAT_EN defined: a=0x7FFF, b=0x0001, sub=0 -> done 4 edges after start, result=0x7FFF, ovfl=1; the same stimulus without the macro gives result=0x8000, ovfl=1.
REQ-029 WIDTH=16, SAT_EN defined: a=0x8000, b=0x0001, sub=1 -> result=0x8000, ovfl=1.
REQ-030 WIDTH=16: a=0x1234, b=0x0FFF, sub=0 -> result=0x2233, ovfl=0 (exercises carry across all slices).
REQ-031 WIDTH=16: start pulsed again during BUSY with new operands -> first result is unaffected; ready stays 0 until after done.
REQ-032 WIDTH=16: rst asserted on the 2nd BUSY edge -> ready=1 on the next cycle, no done pulse, result=0.
REQ-033 WIDTH=4, SAT_EN defined: a=0x5, b=0x4, sub=0 -> done 1 edge after start, result=0x7, ovfl=1; a=0x3, b=0x2, sub=1 -> result=0x1, ovfl=0.

Source files
------------

// File: rtl/sat_addsub_serial.sv
// sat_addsub_serial
//   Signed two's-complement add/subtract of WIDTH-bit operands, computed one
//   4-bit slice per clock (LSB slice first). The carry is kept between slices.
//   Subtraction is done as a + ~b + 1: b is inverted and the carry starts at 1.
//   Signed overflow is found from the operand sign bits and the raw sign bit.
//
//   Optional feature (compile-time macro SAT_ADDSUB_SAT_EN):
//     defined   -> on overflow, result saturates to the most positive or most
//                  negative WIDTH-bit value
//     undefined -> result is the wrapped WIDTH-bit sum
//   In both builds ovfl reports the signed overflow.
module sat_addsub_serial #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sub,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] result,
  output logic                    ovfl
);

  localparam int SLICES = WIDTH / 4;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

`ifdef SAT_ADDSUB_SAT_EN
  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp to the representable range on overflow. Both operands (after
  // inversion for subtract) have the sign of a, so a's sign gives the
  // direction of the overflow.
  function automatic logic signed [WIDTH-1:0] saturate(
    input logic signed [WIDTH-1:0] val,
    input logic                    ov,
    input logic                    neg
  );
    if (!ov)
      return val;
    else if (neg)
      return MIN_NEG;
    else
      return MAX_POS;
  endfunction
`endif

  // Control state
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  // Operands captured at start; slice sums collected in work_p1
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    sub_p0;
  logic [WIDTH-1:0]        work_p1;

  // Current slice datapath
  logic [CNT_W+1:0]        idx;
  logic [3:0]              a_sl;
  logic [3:0]              b_sl;
  logic [4:0]              slice_sum;
  logic [WIDTH-1:0]        raw_sum;
  logic                    b_msb_eff;
  logic                    ovf_det;
  logic signed [WIDTH-1:0] final_res;

  assign idx = {cnt, 2'b00};

  // Slice adder. The full raw sum combines the earlier slices with the
  // current slice, so the last BUSY edge can register the final result.
  always_comb begin
    a_sl      = a_p0[idx +: 4];
    b_sl      = b_p0[idx +: 4] ^ {4{sub_p0}};
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {4'b0000, carry};
    raw_sum   = work_p1;
    raw_sum[idx +: 4] = slice_sum[3:0];
    b_msb_eff = b_p0[WIDTH-1] ^ sub_p0;
    ovf_det   = (a_p0[WIDTH-1] == b_msb_eff) && (raw_sum[WIDTH-1] != a_p0[WIDTH-1]);
`ifdef SAT_ADDSUB_SAT_EN
    final_res = saturate(raw_sum, ovf_det, a_p0[WIDTH-1]);
`else
    final_res = raw_sum;
`endif
  end

  // FSM with registered handshake and result outputs; reset wins over start
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovfl   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= BUSY;
            cnt   <= '0;
            carry <= sub;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          carry <= slice_sum[4];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_SLICE) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= final_res;
            ovfl   <= ovf_det;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0: capture operands on an accepted start; stage p1: store each slice sum
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_p0   <= a;
      b_p0   <= b;
      sub_p0 <= sub;
    end
    if (state == BUSY)
      work_p1[idx +: 4] <= slice_sum[3:0];
  end

endmodule

// File: tb/tb_sat_addsub_serial.sv
// Bench for sat_addsub_serial. It drives a WIDTH=16 and a WIDTH=4 instance.
// An arithmetic reference model predicts each result, and the prediction is
// queued when the operation is launched.
module tb_sat_addsub_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, sub16, start4, sub4;
  logic [15:0] a16, b16;
  logic [3:0]  a4, b4;
  logic        ready16, busy16, done16, ovfl16;
  logic [15:0] result16;
  logic        ready4, busy4, done4, ovfl4;
  logic [3:0]  result4;

  sat_addsub_serial #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .ready(ready16), .busy(busy16), .done(done16), .result(result16), .ovfl(ovfl16)
  );

  sat_addsub_serial #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .result(result4), .ovfl(ovfl4)
  );

  typedef struct {
    logic [15:0] res;
    logic        ov;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer sum, range check, then wrap or clamp
  function automatic exp_t model(input int w, input longint av, input longint bv, input bit s);
    longint sum, maxv, minv, mask;
    exp_t   e;
    maxv  = (longint'(1) <<< (w - 1)) - 1;
    minv  = -(maxv + 1);
    mask  = (longint'(1) << w) - 1;
    sum   = s ? av - bv : av + bv;
    e.ov  = (sum > maxv) || (sum < minv);
    e.res = 16'(sum & mask);
`ifdef SAT_ADDSUB_SAT_EN
    if (sum > maxv)      e.res = 16'(maxv & mask);
    else if (sum < minv) e.res = 16'(minv & mask);
`endif
    return e;
  endfunction

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input bit s,
                       input bit poke, input string tag);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(ready16), 32'd1);
    a16 = av; b16 = bv; sub16 = s; start16 = 1'b1;
    q16.push_back(model(16, longint'($signed(av)), longint'($signed(bv)), s));
    @(negedge clk);
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 1) begin
        chk({tag, "_busy"}, 32'(busy16), 32'd1);
        chk({tag, "_ready_busy"}, 32'(ready16), 32'd0);
        a16 = 16'h5A5A; b16 = 16'h3C3C; sub16 = ~s; start16 = 1'b1;
      end else begin
        start16 = 1'b0;
      end
    end
    start16 = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    if (q16.size() > 0) e = q16.pop_front();
    else begin e.res = 'x; e.ov = 1'bx; end
    chk({tag, "_result"}, 32'(result16), 32'(e.res));
    chk({tag, "_ovfl"}, 32'(ovfl16), 32'(e.ov));
    if (poke) chk({tag, "_ready_at_done"}, 32'(ready16), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done16), 32'd0);
    chk({tag, "_ready_after"}, 32'(ready16), 32'd1);
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input bit s, input string tag);
    exp_t e;
    int   lat;
    @(negedge clk);
    a4 = av; b4 = bv; sub4 = s; start4 = 1'b1;
    q4.push_back(model(4, longint'($signed(av)), longint'($signed(bv)), s));
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (done4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd1);
    if (q4.size() > 0) e = q4.pop_front();
    else begin e.res = 'x; e.ov = 1'bx; end
    chk({tag, "_result"}, 32'(result4), 32'(e.res));
    chk({tag, "_ovfl"}, 32'(ovfl4), 32'(e.ov));
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(ready4), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    start4  = 1'b0; sub4  = 1'b0; a4  = '0; b4  = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready16",  32'(ready16),  32'd1);
    chk("rst_busy16",   32'(busy16),   32'd0);
    chk("rst_done16",   32'(done16),   32'd0);
    chk("rst_result16", 32'(result16), 32'd0);
    chk("rst_ovfl16",   32'(ovfl16),   32'd0);
    chk("rst_ready4",   32'(ready4),   32'd1);
    chk("rst_result4",  32'(result4),  32'd0);
    rst = 1'b0;

    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf_add");
    run16(16'h8000, 16'h0001, 1'b1, 1'b0, "neg_ovf_sub");
    run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, "carry_chain");
    run16(16'h8000, 16'h8000, 1'b0, 1'b0, "neg_ovf_add");
    run16(16'h0000, 16'h8000, 1'b1, 1'b0, "sub_min");
    run16(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, "sub_neg_one");
    run16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, "minus_two");
    run16(16'h0123, 16'h0456, 1'b0, 1'b1, "start_in_busy");
    for (int i = 0; i < 6; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, "random");

    run4(4'h5, 4'h4, 1'b0, "w4_pos_ovf");
    run4(4'h3, 4'h2, 1'b1, "w4_sub");
    run4(4'h8, 4'h1, 1'b1, "w4_neg_ovf");
    run4(4'hF, 4'hF, 1'b0, "w4_minus_two");

    // Abort: reset lands on the second BUSY edge of an operation
    run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, "pre_abort");
    @(negedge clk);
    a16 = 16'h4000; b16 = 16'h4000; sub16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy16), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready",  32'(ready16),  32'd1);
    chk("abort_busy",   32'(busy16),   32'd0);
    chk("abort_done",   32'(done16),   32'd0);
    chk("abort_result", 32'(result16), 32'd0);
    chk("abort_ovfl",   32'(ovfl16),   32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done16 === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run16(16'h0F0F, 16'h00F1, 1'b1, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
